// File: rtl/mmio_router_pkg.sv
// Shared constants for the MMIO router: FSM state codes, field widths and a width helper.
package mmio_router_pkg;

    localparam int CODE_W = 4;
    localparam int CNT_W  = 4;
    localparam int BE_W   = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Keeps index vectors at least one bit wide for single-device builds.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_router_decode.sv
// Region-code compare against every device code; lowest device index wins on duplicate codes.
module mmio_router_decode
    import mmio_router_pkg::*;
#(
    parameter int                       NUM_DEV  = 4,
    parameter int                       IDX_W    = 2,
    parameter logic [NUM_DEV*CODE_W-1:0] DEV_CODE = 16'hfedc
) (
    input  logic [CODE_W-1:0]  code,
    input  logic               req,
    output logic [NUM_DEV-1:0] hit,
    output logic [IDX_W-1:0]   idx,
    output logic               any_hit
);

    always_comb begin
        hit     = '0;
        idx     = '0;
        any_hit = 1'b0;
        // Walk downwards so the lowest matching index is the last one written.
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (req && (code == DEV_CODE[i*CODE_W +: CODE_W])) begin
                hit     = '0;
                hit[i]  = 1'b1;
                idx     = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_router.sv
// Data-side address router: device decode, cache passthrough, read mux and per-device wait sequencing.
//
// state  | meaning
// IDLE   | no device access in flight; a waited-device hit starts one
// ACCESS | counting wait cycles, dev_wen held for a write, cpu stalled
// DONE   | access finished, stall released; held here while pipe_hold is high
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter int                       ADDR_W   = 30,
    parameter int                       DATA_W   = 32,
    parameter int                       NUM_DEV  = 4,
    parameter int                       SEL_LO   = 26,
    parameter logic [NUM_DEV*CODE_W-1:0] DEV_CODE = {4'hf, 4'he, 4'hd, 4'hc},
    parameter logic [NUM_DEV*CNT_W-1:0]  DEV_WAIT = {4'd0, 4'd0, 4'd0, 4'd2}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    input  logic [BE_W-1:0]           cpu_be,
    input  logic                      pipe_hold,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_stall,
    output logic [NUM_DEV-1:0]        dev_sel,
    output logic [NUM_DEV-1:0]        dev_wen,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    output logic [BE_W-1:0]           dev_be,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata
);

    localparam int IDX_W = idx_width(NUM_DEV);

    logic               req;
    logic [NUM_DEV-1:0] hit;
    logic [IDX_W-1:0]   idx;
    logic               any_hit;
    logic [CNT_W-1:0]   hit_wait;
    logic [CNT_W-1:0]   lat_wait;
    logic [NUM_DEV-1:0] wen_zero;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DEV-1:0] wen_q, wen_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;

    assign req = cpu_read | cpu_write;

    mmio_router_decode #(
        .NUM_DEV  (NUM_DEV),
        .IDX_W    (IDX_W),
        .DEV_CODE (DEV_CODE)
    ) u_decode (
        .code    (cpu_addr[SEL_LO +: CODE_W]),
        .req     (req),
        .hit     (hit),
        .idx     (idx),
        .any_hit (any_hit)
    );

    assign hit_wait = DEV_WAIT[int'(idx)   * CNT_W +: CNT_W];
    assign lat_wait = DEV_WAIT[int'(idx_q) * CNT_W +: CNT_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (any_hit && (hit_wait != '0)) begin
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    be_d       = cpu_be;
                    idx_d      = idx;
                    cnt_d      = CNT_W'(1);
                    wen_d      = '0;
                    wen_d[idx] = cpu_write;
                    state_d    = ST_ACCESS;
                end
            end
            // Runs to completion even if the request drops, so a write is never cut short.
            ST_ACCESS: begin
                if (cnt_q == lat_wait) begin
                    wen_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                wen_d = '0;
                if (!pipe_hold) state_d = ST_IDLE;
            end
            default: begin
                wen_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign wen_zero = (any_hit && (hit_wait == '0) && cpu_write) ? hit : '0;

    assign dev_sel   = hit;
    assign dev_wen   = wen_q | wen_zero;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev_be    = be_q;

    assign mem_read  = cpu_read  & ~any_hit;
    assign mem_write = cpu_write & ~any_hit;

    always_comb begin
        cpu_rdata = '0;
        if (any_hit)  cpu_rdata = dev_rdata[int'(idx) * DATA_W +: DATA_W];
        else if (req) cpu_rdata = mem_rdata;
    end

    always_comb begin
        cpu_stall = mem_stall;
        if (any_hit) cpu_stall = (hit_wait != '0) && (state_q != ST_DONE);
    end

endmodule
